// File: rtl/fork_launch.sv
// fork_launch: turns fork contexts from the fork stage into one-at-a-time core
// launches. Each core runs a small IDLE/PEND/RUN/RELEASE lifecycle; pending
// cores are granted by fixed priority (lowest index first), one per cycle.
module fork_launch #(
   parameter int NCORES = 4,
   parameter int CXTW   = 33
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic [NCORES*CXTW-1:0] fork_cxt_in,
   input  logic [NCORES-1:0]      core_ens_in,
   input  logic [NCORES-1:0]      core_halt,
   output logic [NCORES-1:0]      core_ens_out,
   output logic [NCORES-1:0]      fork_cxt_clr,
   output logic [NCORES-1:0]      core_start,
   output logic [15:0]            start_pc,
   output logic [15:0]            start_ptr,
   output logic [NCORES-1:0]      running,
   output logic [7:0]             launch_cnt,
   output logic                   err
);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_PEND = 2'd1,
      ST_RUN  = 2'd2,
      ST_REL  = 2'd3
   } state_t;

   state_t            state_q [NCORES];
   state_t            state_d [NCORES];

   logic [NCORES-1:0] cxt_valid_s;
   logic [NCORES-1:0] req_s;
   logic [NCORES-1:0] run_s;
   logic [NCORES-1:0] release_s;
   logic [NCORES-1:0] grant_s;
   logic              found_s;
   logic [15:0]       sel_pc_s;
   logic [15:0]       sel_ptr_s;

   logic [NCORES-1:0] core_start_q;
   logic [NCORES-1:0] fork_cxt_clr_q;
   logic [15:0]       start_pc_q;
   logic [15:0]       start_ptr_q;
   logic [7:0]        launch_cnt_q;
   logic              err_q;

   // Unpack per-core valid bits and decode the per-core lifecycle state.
   always_comb begin
      cxt_valid_s = '0;
      run_s       = '0;
      release_s   = '0;
      for (int i = 0; i < NCORES; i++) begin
         cxt_valid_s[i] = fork_cxt_in[i*CXTW + 32];
         run_s[i]       = (state_q[i] == ST_RUN);
         release_s[i]   = (state_q[i] == ST_REL);
      end
      req_s = cxt_valid_s & core_ens_in;
   end

   // Fixed-priority grant to the lowest pending core whose request is still live.
   always_comb begin
      grant_s   = '0;
      found_s   = 1'b0;
      sel_pc_s  = 16'd0;
      sel_ptr_s = 16'd0;
      for (int i = 0; i < NCORES; i++) begin
         if (!found_s && (state_q[i] == ST_PEND) && req_s[i]) begin
            grant_s[i] = 1'b1;
            found_s    = 1'b1;
            sel_pc_s   = fork_cxt_in[i*CXTW      +: 16];
            sel_ptr_s  = fork_cxt_in[i*CXTW + 16 +: 16];
         end else begin
            grant_s[i] = 1'b0;
         end
      end
   end

   // Next-state logic for every core's lifecycle.
   always_comb begin
      for (int i = 0; i < NCORES; i++) begin
         state_d[i] = state_q[i];
         case (state_q[i])
            ST_IDLE: begin
               if (req_s[i]) state_d[i] = ST_PEND;
               else          state_d[i] = ST_IDLE;
            end
            ST_PEND: begin
               // A request that drops before its grant abandons the launch.
               if (grant_s[i])    state_d[i] = ST_RUN;
               else if (req_s[i]) state_d[i] = ST_PEND;
               else               state_d[i] = ST_IDLE;
            end
            ST_RUN: begin
               // Halt is ignored in the launch cycle itself.
               if (core_halt[i] && !core_start_q[i]) state_d[i] = ST_REL;
               else                                  state_d[i] = ST_RUN;
            end
            ST_REL:  state_d[i] = ST_IDLE;
            default: state_d[i] = ST_IDLE;
         endcase
      end
   end

   // State, launch pulses, captured launch context, counter and sticky error.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < NCORES; i++) begin
            state_q[i] <= (i == 0) ? ST_RUN : ST_IDLE;
         end
         core_start_q   <= '0;
         fork_cxt_clr_q <= '0;
         start_pc_q     <= 16'd0;
         start_ptr_q    <= 16'd0;
         launch_cnt_q   <= 8'd0;
         err_q          <= 1'b0;
      end else begin
         for (int i = 0; i < NCORES; i++) begin
            state_q[i] <= state_d[i];
         end
         core_start_q   <= grant_s;
         fork_cxt_clr_q <= grant_s;
         if (|grant_s) begin
            start_pc_q   <= sel_pc_s;
            start_ptr_q  <= sel_ptr_s;
            launch_cnt_q <= launch_cnt_q + 8'd1;
         end else begin
            start_pc_q   <= start_pc_q;
            start_ptr_q  <= start_ptr_q;
            launch_cnt_q <= launch_cnt_q;
         end
         // A fresh fork aimed at a core that is already running is a protocol error.
         err_q <= err_q | (|(cxt_valid_s & run_s & ~core_start_q));
      end
   end

   assign core_ens_out = core_ens_in & ~release_s;
   assign running      = run_s;
   assign core_start   = core_start_q;
   assign fork_cxt_clr = fork_cxt_clr_q;
   assign start_pc     = start_pc_q;
   assign start_ptr    = start_ptr_q;
   assign launch_cnt   = launch_cnt_q;
   assign err          = err_q;

endmodule

// File: doc/fork_launch.md
FORK_LAUNCH -- requirements
Module: fork_launch

Interface
- REQ-001: Parameter NCORES, default 4, is the number of cores; legal range 2..16.
- REQ-002: Parameter CXTW, default 33, is the per-core fork context width; fixed packing per core i at bits [i*33+32 : i*33]: [32]=valid, [31:16]=ptr, [15:0]=pc.
- REQ-003: clk  in  1  single clock; all state updates on rising edge.
- REQ-004: rst  in  1  synchronous, active-high reset.
- REQ-005: fork_cxt_in  in  NCORES*33  fork contexts produced by the fork stage.
- REQ-006: core_ens_in  in  NCORES  core enables from the fork stage.
- REQ-007: core_halt  in  NCORES  core i has finished its thread (level or pulse).
- REQ-008: core_ens_out  out  NCORES  enables after release masking (combinational).
- REQ-009: fork_cxt_clr  out  NCORES  registered one-cycle pulse; clears valid bit of context i upstream.
- REQ-010: core_start  out  NCORES  registered one-hot pulse; core i loads start_pc/start_ptr.
- REQ-011: start_pc  out  16  launch program counter; valid only while core_start != 0.
- REQ-012: start_ptr  out  16  launch data pointer; valid only while core_start != 0.
- REQ-013: running  out  NCORES  core i is in RUN.
- REQ-014: launch_cnt  out  8  total launches, wraps 255->0.
- REQ-015: err  out  1  sticky protocol-error flag.

Function
- REQ-016: Each core i has a 2-bit FSM: IDLE, PEND, RUN, RELEASE.
- REQ-017: IDLE->PEND when context i valid=1 and core_ens_in[i]=1; else stay.
- REQ-018: PEND: grant goes to the lowest-index core in PEND; at most one grant per cycle.
- REQ-019: Granted core: next cycle core_start[i]=1, fork_cxt_clr[i]=1, start_pc/start_ptr = context i pc/ptr as sampled in grant cycle; FSM -> RUN.
- REQ-020: Ungranted PEND cores stay PEND; no starvation bound beyond fixed priority.
- REQ-021: PEND->IDLE without launch if context valid or core_ens_in[i] drops before grant.
- REQ-022: Uncontended latency: context valid sampled at edge N -> core_start visible in cycle N+2.
- REQ-023: RUN->RELEASE on core_halt[i]=1; core_halt ignored in the cycle core_start[i]=1 and in all non-RUN states.
- REQ-024: RELEASE lasts exactly one cycle, then IDLE.
- REQ-025: core_ens_out[i] = 0 while state RELEASE, else core_ens_in[i].
- REQ-026: running[i] = 1 iff state RUN.
- REQ-027: launch_cnt increments by 1 on each cycle with core_start != 0.
- REQ-028: err set when context i valid=1 while core i in RUN and core_start[i]=0; cleared only by rst.
- REQ-029: start_pc/start_ptr hold last launched values when core_start=0.
- REQ-030: Context i newly valid in the cycle core i leaves RELEASE is taken normally from IDLE next cycle.

Reset
- REQ-031: With rst=1 at an edge: core 0 FSM=RUN (root thread), cores 1..NCORES-1=IDLE.
- REQ-032: Reset values: core_start=0, fork_cxt_clr=0, start_pc=0, start_ptr=0, launch_cnt=0, err=0; running=1 for core 0 only.
- REQ-033: rst asserted mid-launch discards pending grants; no core_start or fork_cxt_clr in the cycle after reset.

Verification
- REQ-034: NCORES=4, after reset, context 2 = {1,ptr=0x0040,pc=0x0123}, core_ens_in[2]=1 at edge N -> cycle N+2: core_start=0100, fork_cxt_clr=0100, start_pc=0x0123, start_ptr=0x0040, launch_cnt=1.
- REQ-035: Contexts 1 and 3 valid in same cycle -> core_start=0010 first, core_start=1000 exactly one cycle later, launch_cnt=2.
- REQ-036: Core 2 in RUN, core_halt[2]=1 -> next cycle running[2]=0, core_ens_out[2]=0 for one cycle while core_ens_in[2]=1, then follows core_ens_in.
- REQ-037: Core 1 in PEND behind core 0... contested, context 1 valid drops before grant -> no core_start[1], FSM returns IDLE, launch_cnt unchanged.
- REQ-038: Context 0 valid while core 0 RUN -> err=1 next cycle, stays 1 until rst; 256 launches -> launch_cnt=0.
